// File: rtl/lcd_timing_driver.sv
// LCD panel timing generator: free-running line/frame counters produce registered
// sync, data-enable and pixel-request signals; lcd_rgb gates the incoming pixel data.
module lcd_timing_driver #(
   parameter int unsigned H_SYNC   = 128,
   parameter int unsigned H_BACK   = 88,
   parameter int unsigned H_DISP   = 800,
   parameter int unsigned H_FRONT  = 40,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BACK   = 33,
   parameter int unsigned V_DISP   = 480,
   parameter int unsigned V_FRONT  = 10,
   parameter int unsigned DATA_LAT = 2
) (
   input  logic        pixel_clk,
   input  logic        sys_rst_n,
   input  logic [23:0] pixel_data,
   output logic [11:0] pixel_xpos,
   output logic [11:0] pixel_ypos,
   output logic        data_req,
   output logic        lcd_hs,
   output logic        lcd_vs,
   output logic        lcd_de,
   output logic [23:0] lcd_rgb,
   output logic        frame_start
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

   localparam logic [11:0] HLast = 12'(H_TOTAL - 1);
   localparam logic [11:0] VLast = 12'(V_TOTAL - 1);

   // Region bounds kept 14 bits wide so an end bound of 4096 and h+DATA_LAT never wrap
   localparam logic [13:0] HSyncEnd = 14'(H_SYNC);
   localparam logic [13:0] HDeBeg   = 14'(H_SYNC + H_BACK);
   localparam logic [13:0] HDeEnd   = 14'(H_SYNC + H_BACK + H_DISP);
   localparam logic [13:0] VSyncEnd = 14'(V_SYNC);
   localparam logic [13:0] VDeBeg   = 14'(V_SYNC + V_BACK);
   localparam logic [13:0] VDeEnd   = 14'(V_SYNC + V_BACK + V_DISP);
   localparam logic [13:0] DataLat  = 14'(DATA_LAT);

   logic [11:0] h_cnt_q, h_cnt_d;
   logic [11:0] v_cnt_q, v_cnt_d;

   logic [13:0] h_w, v_w, xr_w;
   logic        v_act;
   logic        hs_d, vs_d, de_d, req_d, fs_d;
   logic [11:0] xpos_d, ypos_d;

   // Next counter values: h wraps every line, v advances on h wrap and wraps per frame
   always_comb begin
      h_cnt_d = (h_cnt_q == HLast) ? 12'd0 : h_cnt_q + 12'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == HLast) begin
         v_cnt_d = (v_cnt_q == VLast) ? 12'd0 : v_cnt_q + 12'd1;
      end
   end

   // Decode outputs from the next counter values so the registered outputs line up
   // with the counters in the same cycle
   always_comb begin
      h_w    = {2'b00, h_cnt_d};
      v_w    = {2'b00, v_cnt_d};
      // Request column is h shifted ahead by DATA_LAT; unsigned compare against the
      // display start avoids negative aliasing
      xr_w   = h_w + DataLat;
      v_act  = (v_w >= VDeBeg) && (v_w < VDeEnd);
      hs_d   = (h_w >= HSyncEnd);
      vs_d   = (v_w >= VSyncEnd);
      de_d   = (h_w >= HDeBeg) && (h_w < HDeEnd) && v_act;
      req_d  = (xr_w >= HDeBeg) && (xr_w < HDeEnd) && v_act;
      xpos_d = 12'd0;
      ypos_d = 12'd0;
      if (req_d) begin
         xpos_d = xr_w[11:0] - HDeBeg[11:0];
         ypos_d = v_cnt_d - VDeBeg[11:0];
      end
      fs_d   = (h_cnt_d == 12'd0) && (v_cnt_d == 12'd0);
   end

   // Counter and output registers; reset parks counters at the last position so the
   // first edge after release lands on (0,0)
   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         h_cnt_q     <= HLast;
         v_cnt_q     <= VLast;
         lcd_hs      <= 1'b1;
         lcd_vs      <= 1'b1;
         lcd_de      <= 1'b0;
         data_req    <= 1'b0;
         pixel_xpos  <= 12'd0;
         pixel_ypos  <= 12'd0;
         frame_start <= 1'b0;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         lcd_hs      <= hs_d;
         lcd_vs      <= vs_d;
         lcd_de      <= de_d;
         data_req    <= req_d;
         pixel_xpos  <= xpos_d;
         pixel_ypos  <= ypos_d;
         frame_start <= fs_d;
      end
   end

   // Pixel data passes straight through only inside the display window
   assign lcd_rgb = lcd_de ? pixel_data : 24'h000000;

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Directed bench for lcd_timing_driver: a default-parameter instance (A) and a small
// display with DATA_LAT=0 (B), each compared cycle by cycle against hand-derived timing.
module tb_lcd_timing_driver;

   // Default timing, instance A
   localparam int HT_A = 1056;
   localparam int VT_A = 525;
   // Small display timing, instance B: 128+88+16+40, 2+33+4+10
   localparam int HT_B = 272;
   localparam int VT_B = 49;

   logic pixel_clk = 1'b0;
   always #5 pixel_clk = ~pixel_clk;

   logic        rst_a, rst_b;
   logic [23:0] pd_a, pd_b;
   logic [11:0] xpos_a, ypos_a, xpos_b, ypos_b;
   logic        req_a, hs_a, vs_a, de_a, fs_a;
   logic        req_b, hs_b, vs_b, de_b, fs_b;
   logic [23:0] rgb_a, rgb_b;

   int n_checks = 0;
   int n_errors = 0;

   logic [23:0] p1, p2;
   int  seen_req, req_rise_h, req_rise_x, req_rise_y;
   int  de_rise_h, de_fall_h, de_cnt;
   logic prev_de;

   lcd_timing_driver u_dut_a (
      .pixel_clk  (pixel_clk),
      .sys_rst_n  (rst_a),
      .pixel_data (pd_a),
      .pixel_xpos (xpos_a),
      .pixel_ypos (ypos_a),
      .data_req   (req_a),
      .lcd_hs     (hs_a),
      .lcd_vs     (vs_a),
      .lcd_de     (de_a),
      .lcd_rgb    (rgb_a),
      .frame_start(fs_a)
   );

   lcd_timing_driver #(
      .H_DISP  (16),
      .V_DISP  (4),
      .DATA_LAT(0)
   ) u_dut_b (
      .pixel_clk  (pixel_clk),
      .sys_rst_n  (rst_b),
      .pixel_data (pd_b),
      .pixel_xpos (xpos_b),
      .pixel_ypos (ypos_b),
      .data_req   (req_b),
      .lcd_hs     (hs_b),
      .lcd_vs     (vs_b),
      .lcd_de     (de_b),
      .lcd_rgb    (rgb_b),
      .frame_start(fs_b)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic check_reset_a(input string tag);
      check_val({tag, " hs"},    32'(hs_a), 32'd1);
      check_val({tag, " vs"},    32'(vs_a), 32'd1);
      check_val({tag, " de"},    32'(de_a), 32'd0);
      check_val({tag, " req"},   32'(req_a), 32'd0);
      check_val({tag, " xpos"},  32'(xpos_a), 32'd0);
      check_val({tag, " ypos"},  32'(ypos_a), 32'd0);
      check_val({tag, " fs"},    32'(fs_a), 32'd0);
      check_val({tag, " rgb"},   32'(rgb_a), 32'd0);
   endtask

   // Instance A: n cycles from reset release; pixel source returns {y,x} two cycles late
   task automatic run_a(input int n);
      int h, v, xr;
      logic de_e, req_e, vact;
      logic [31:0] rgb_e;
      for (int k = 0; k < n; k++) begin
         @(posedge pixel_clk);
         #1;
         h = k % HT_A;
         v = (k / HT_A) % VT_A;
         pd_a = p2;
         p2 = p1;
         p1 = {ypos_a, xpos_a};
         #1;
         vact  = (v >= 35) && (v < 515);
         de_e  = (h >= 216) && (h < 1016) && vact;
         xr    = h + 2 - 216;
         req_e = (xr >= 0) && (xr < 800) && vact;
         rgb_e = de_e ? ((32'(v - 35) << 12) | 32'(h - 216)) : 32'd0;
         check_val("a hs",   32'(hs_a),   32'(h >= 128));
         check_val("a vs",   32'(vs_a),   32'(v >= 2));
         check_val("a de",   32'(de_a),   32'(de_e));
         check_val("a req",  32'(req_a),  32'(req_e));
         check_val("a xpos", 32'(xpos_a), req_e ? 32'(xr) : 32'd0);
         check_val("a ypos", 32'(ypos_a), req_e ? 32'(v - 35) : 32'd0);
         check_val("a fs",   32'(fs_a),   32'((h == 0) && (v == 0)));
         check_val("a rgb",  32'(rgb_a),  rgb_e);
         if (v == 35) begin
            if (req_a && seen_req == 0) begin
               seen_req   = 1;
               req_rise_h = h;
               req_rise_x = int'(xpos_a);
               req_rise_y = int'(ypos_a);
            end
            if (de_a && !prev_de) de_rise_h = h;
            if (!de_a && prev_de) de_fall_h = h;
            if (de_a) de_cnt++;
         end
         prev_de = de_a;
      end
   endtask

   // Instance B: two full frames plus a few cycles, constant pixel data
   task automatic run_b();
      int h, v, fs_n, fs_first, fs_second, max_x, max_y, req_n;
      logic de_e;
      fs_n = 0; fs_first = -1; fs_second = -1; max_x = 0; max_y = 0; req_n = 0;
      for (int k = 0; k < 2 * HT_B * VT_B + 5; k++) begin
         @(posedge pixel_clk);
         #2;
         h = k % HT_B;
         v = (k / HT_B) % VT_B;
         de_e = (h >= 216) && (h < 232) && (v >= 35) && (v < 39);
         check_val("b de",   32'(de_b),   32'(de_e));
         check_val("b req",  32'(req_b),  32'(de_e));
         check_val("b xpos", 32'(xpos_b), de_e ? 32'(h - 216) : 32'd0);
         check_val("b ypos", 32'(ypos_b), de_e ? 32'(v - 35) : 32'd0);
         check_val("b fs",   32'(fs_b),   32'((h == 0) && (v == 0)));
         check_val("b rgb",  32'(rgb_b),  de_e ? 32'h5A5A5A : 32'd0);
         if (req_b) begin
            req_n++;
            if (int'(xpos_b) > max_x) max_x = int'(xpos_b);
            if (int'(ypos_b) > max_y) max_y = int'(ypos_b);
         end
         if (fs_b) begin
            fs_n++;
            if (fs_first < 0) fs_first = k;
            else if (fs_second < 0) fs_second = k;
         end
      end
      check_val("b fs count",  32'(fs_n), 32'd3);
      check_val("b fs period", 32'(fs_second - fs_first), 32'd13328);
      check_val("b max xpos",  32'(max_x), 32'd15);
      check_val("b max ypos",  32'(max_y), 32'd3);
      check_val("b req count", 32'(req_n), 32'd128);
   endtask

   initial begin
      rst_a = 1'b0;
      rst_b = 1'b0;
      pd_a  = 24'hABCDEF;
      pd_b  = 24'h5A5A5A;
      p1 = '0; p2 = '0;
      seen_req = 0; req_rise_h = -1; req_rise_x = -1; req_rise_y = -1;
      de_rise_h = -1; de_fall_h = -1; de_cnt = 0; prev_de = 1'b0;

      repeat (3) @(posedge pixel_clk);
      #1;
      check_reset_a("hold");
      check_val("b hold de",  32'(de_b), 32'd0);
      check_val("b hold fs",  32'(fs_b), 32'd0);
      check_val("b hold rgb", 32'(rgb_b), 32'd0);

      @(negedge pixel_clk);
      rst_a = 1'b1;
      rst_b = 1'b1;
      pd_a  = 24'h0;

      // Run A up to v=36, h=500 (mid display), B concurrently for two frames
      fork
         run_a(36 * HT_A + 501);
         run_b();
      join

      check_val("req rise h",   32'(req_rise_h), 32'd214);
      check_val("req rise x",   32'(req_rise_x), 32'd0);
      check_val("req rise y",   32'(req_rise_y), 32'd0);
      check_val("de rise h",    32'(de_rise_h), 32'd216);
      check_val("de fall h",    32'(de_fall_h), 32'd1016);
      check_val("de line cnt",  32'(de_cnt), 32'd800);

      // Asynchronous reset mid-line: outputs must drop before any clock edge
      #1;
      pd_a  = 24'h123456;
      rst_a = 1'b0;
      #1;
      check_reset_a("async");
      repeat (2) @(posedge pixel_clk);
      #1;
      check_reset_a("hold2");

      @(negedge pixel_clk);
      rst_a = 1'b1;
      pd_a  = 24'h0;
      p1 = '0; p2 = '0;
      run_a(300);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lcd_timing_driver.md
LCD_TIMING_DRIVER -- requirements
Module: lcd_timing_driver

Interface
REQ-001 Parameters SHALL be:
- H_SYNC, 128: hsync width, pixel clocks.
- H_BACK, 88: horizontal back porch.
- H_DISP, 800: active pixels per line.
- H_FRONT, 40: horizontal front porch.
- V_SYNC, 2: vsync width, lines.
- V_BACK, 33: vertical back porch.
- V_DISP, 480: active lines.
- V_FRONT, 10: vertical front porch.
- DATA_LAT, 2: cycles from pixel_xpos/pixel_ypos to valid pixel_data.
REQ-002 Derived values SHALL be H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT (default 1056) and V_TOTAL = V_SYNC+V_BACK+V_DISP+V_FRONT (default 525); H_TOTAL, V_TOTAL SHALL each be at most 4096.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be:
- pixel_clk, in, 1: pixel clock.
- sys_rst_n, in, 1: asynchronous active-low reset.
- pixel_data, in, 24: RGB888 from the pixel source.
- pixel_xpos, out, 12: requested pixel column.
- pixel_ypos, out, 12: requested pixel row.
- data_req, out, 1: request window is active.
- lcd_hs, out, 1: hsync, active low.
- lcd_vs, out, 1: vsync, active low.
- lcd_de, out, 1: data enable, active high.
- lcd_rgb, out, 24: panel pixel data.
- frame_start, out, 1: one-cycle pulse at the start of each frame.

Function
REQ-005 Internal counter h_cnt SHALL count 0..H_TOTAL-1 and increment every cycle, wrapping to 0.
REQ-006 Internal counter v_cnt SHALL count 0..V_TOTAL-1, increment when h_cnt wraps, and wrap to 0 when both counters are at their maximum.
REQ-007 Horizontal line order SHALL be sync, then back porch, then display, then front porch; the vertical frame SHALL use the same order.
REQ-008 All outputs except lcd_rgb SHALL be registered, and at cycle t each SHALL reflect the counter values held at cycle t.
REQ-009 lcd_hs SHALL be 0 iff h_cnt < H_SYNC.
REQ-010 lcd_vs SHALL be 0 iff v_cnt < V_SYNC.
REQ-011 lcd_de SHALL be 1 iff h_cnt is in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and v_cnt is in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP).
REQ-012 Let xr = h_cnt + DATA_LAT - H_SYNC - H_BACK. data_req SHALL be 1 iff xr is in [0, H_DISP) and v_cnt is in the vertical display range.
REQ-013 While data_req=1: pixel_xpos SHALL be xr and pixel_ypos SHALL be v_cnt - V_SYNC - V_BACK; while data_req=0, both SHALL be 0.
REQ-014 Pixel alignment: the pixel requested at cycle t SHALL be shown with lcd_de=1 at cycle t+DATA_LAT.
REQ-015 lcd_rgb SHALL be pixel_data when lcd_de=1, otherwise 24'h000000; this is a combinational mux with no added latency.
REQ-016 frame_start SHALL be 1 for exactly the one cycle where h_cnt=0 and v_cnt=0.
REQ-017 DATA_LAT SHALL satisfy 0 <= DATA_LAT <= H_SYNC+H_BACK, so the request window never crosses a line boundary.
REQ-018 Arithmetic SHALL be 12-bit unsigned, with xr evaluated wide enough that negative values never alias into [0, H_DISP).

Reset
REQ-019 While sys_rst_n=0, the block SHALL hold h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
REQ-020 While sys_rst_n=0, outputs SHALL be lcd_hs=1, lcd_vs=1, lcd_de=0, data_req=0, pixel_xpos=0, pixel_ypos=0, frame_start=0 and lcd_rgb=0.
REQ-021 Reset assertion SHALL take effect immediately, including mid-line or mid-frame.
REQ-022 At the first pixel_clk edge after reset release, the counters SHALL go to (0,0) and frame_start SHALL pulse.

Verification
REQ-023 Release reset at default parameters -> frame_start=1 on the first edge; lcd_hs=0 for h_cnt 0..127; lcd_vs=0 for lines 0..1.
REQ-024 On line v_cnt=35 -> data_req rises at h_cnt=214 with pixel_xpos=0 and pixel_ypos=0; lcd_de rises at h_cnt=216; lcd_de falls at h_cnt=1016 after 800 cycles high.
REQ-025 Drive pixel_data = {pixel_ypos, pixel_xpos} delayed by 2 cycles -> at each lcd_de=1 cycle, lcd_rgb equals {y,x} for the matching column; lcd_rgb=0 whenever lcd_de=0.
REQ-026 Lines v_cnt=515..524 and 0..34 -> lcd_de=0 and data_req=0 throughout; frame_start period is exactly 1056*525 = 554400 cycles.
REQ-027 Assert sys_rst_n=0 at h_cnt=500, v_cnt=100 -> all outputs reach their reset values without waiting for a clock edge; after release, the timing restarts at (0,0) with frame_start=1.
REQ-028 Run with DATA_LAT=0 and H_DISP=16, V_DISP=4 -> data_req coincides with lcd_de every cycle; pixel_xpos spans 0..15 and pixel_ypos spans 0..3.
